// File: rtl/fp_add_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_arb_pkg
//  Purpose  : Shared widths, latency and helpers for the FpAdd arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package fp_add_arb_pkg;

    localparam int FP_W       = 27;
    localparam int FP_EXP_W   = 8;
    localparam int FP_MANT_W  = 18;
    localparam int FP_ADD_LAT = 3;

    typedef logic [FP_W-1:0] fp_t;

    // Width of a requester ID; kept at least one bit so two requesters still fit.
    function automatic int req_id_w(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_arbiter_if
//  Purpose  : Requester, adder and response bundle of the FpAdd arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface fp_add_arbiter_if
    import fp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = FP_W,
    parameter int LAT  = FP_ADD_LAT
);
    localparam int ID_W  = req_id_w(NREQ);
    localparam int CNT_W = $clog2(LAT + 3);

    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic [W-1:0]        add_a;
    logic [W-1:0]        add_b;
    logic [W-1:0]        add_sum;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [W-1:0]        rsp_sum;
    logic [CNT_W-1:0]    inflight;
    logic                idle;

    // Arbiter side
    modport slave (
        input  en, req_valid, req_a, req_b, add_sum,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, inflight, idle
    );

    // Requesters, sequencer and adder side
    modport master (
        output en, req_valid, req_a, req_b, add_sum,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, inflight, idle
    );

endinterface
`default_nettype wire

// File: rtl/fp_add_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin grant with a pointer that advances past each winner.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = req_id_w(NREQ)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [NREQ-1:0] req,
    input  wire logic            en,
    output logic      [NREQ-1:0] grant,
    output logic      [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            found;

    // First valid requester at or above the pointer, wrapping modulo NREQ
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && en && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Pointer moves to the slot just after the winner, holds otherwise
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_arbiter
//  Purpose  : Shares one pipelined FpAdd among NREQ requesters and returns
//             each sum tagged with the issuing requester's ID.
//  Revision : 1.0  initial release
// ============================================================================
module fp_add_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = FP_W,
    parameter int LAT  = FP_ADD_LAT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fp_add_arbiter_if.slave bus
);

    localparam int ID_W  = req_id_w(NREQ);
    localparam int CNT_W = $clog2(LAT + 3);

    logic [NREQ-1:0]         grant;
    logic [ID_W-1:0]         grant_id;
    logic                    accept;
    logic                    arb_en;

    logic [W-1:0]            add_a_q, add_a_d;
    logic [W-1:0]            add_b_q, add_b_d;
    logic [LAT:0]            trk_v_q, trk_v_d;
    logic [LAT:0][ID_W-1:0]  trk_id_q, trk_id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
    logic [W-1:0]            rsp_sum_q, rsp_sum_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;

    // Grants are suppressed while reset is held so nothing is handshaken then
    assign arb_en = bus.en & rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.req_valid),
        .en       (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Only valid requesters are ever granted, so any grant is an accept
    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.inflight  = inflight_q;
    assign bus.idle      = (inflight_q == '0);

    // Next-state: operand capture, tracker shift, response capture, occupancy
    always_comb begin
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        if (accept) begin
            add_a_d = bus.req_a[grant_id*W +: W];
            add_b_d = bus.req_b[grant_id*W +: W];
        end

        trk_v_d  = {trk_v_q[LAT-1:0], accept};
        trk_id_d = {trk_id_q[LAT-1:0], (accept ? grant_id : {ID_W{1'b0}})};

        // The tail lines up with the adder output of the same operation
        rsp_valid_d = trk_v_q[LAT];
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        if (trk_v_q[LAT]) begin
            rsp_id_d  = trk_id_q[LAT];
            rsp_sum_d = bus.add_sum;
        end

        // An operation leaves the count on the edge that raises its strobe
        inflight_d = inflight_q;
        case ({accept, trk_v_q[LAT]})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            trk_v_q     <= '0;
            trk_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            inflight_q  <= '0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            trk_v_q     <= trk_v_d;
            trk_id_q    <= trk_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Round-robin arbiter and sequencer sharing one pipelined 27-bit `FpAdd` instance among `NREQ` requesters, such as the per-body force/position accumulators in the gravity simulator. It accepts at most one operand pair per cycle and drives the `FpAdd` inputs. A valid/ID pipeline matched to the adder latency tracks each issued operation, so every sum is returned tagged with the ID of the requester that issued it. An enable input and an idle output let the top-level sequencer quiesce the adder between simulation steps.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 27: float width, from package `FP_W`.
- `LAT`, 3: `FpAdd` latency in cycles, measured from the edge that registers its operands to the edge after which `sum` is stable.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `en` in 1: grant enable; when low, no new grants are issued and in-flight operations drain.
- `req_valid` in NREQ: per-requester request.
- `req_ready` out NREQ: per-requester grant (one-hot or zero).
- `req_a` in NREQ*W: operand A, requester i at `[i*W +: W]`.
- `req_b` in NREQ*W: operand B, same packing as `req_a`.
- `add_a` out W: operand A to `FpAdd` `in1`, registered.
- `add_b` out W: operand B to `FpAdd` `in2`, registered.
- `add_sum` in W: result from `FpAdd` `sum`.
- `rsp_valid` out 1: single-cycle result strobe.
- `rsp_id` out clog2(NREQ): requester ID of the returned result.
- `rsp_sum` out W: returned result.
- `inflight` out clog2(LAT+3): number of operations issued but not yet returned.
- `idle` out 1: high when `inflight == 0`.

## Operation
- **Grant:** `req_ready[i]` is high when `en` is high and i is the first valid requester searching upward from pointer `ptr`, wrapping modulo NREQ.
  - `req_ready` is combinational from `req_valid`, `en` and `ptr`.
  - At most one bit is set.
- **Accept:** a request is accepted when `req_valid[i] && req_ready[i]` at a rising edge (edge E0).
- **On accept:**
  - `add_a`/`add_b` load `req_a[i]`/`req_b[i]`.
  - `ptr` becomes (i+1) mod NREQ.
  - The tracker shifts in {1, i}.
- **No accept:** `add_a`/`add_b` hold their values, `ptr` holds, and the tracker shifts in {0, 0}.
- **Tracker:** a shift register of depth LAT+1 holding {valid, id}.
  - Its tail, together with `add_sum`, is registered into `rsp_valid`/`rsp_id`/`rsp_sum`.
  - `rsp_sum` and `rsp_id` update only when the tail is valid and hold otherwise.
- **Results:** there is no result backpressure. Requesters must sink `rsp_valid` whenever their ID matches.
- **inflight counter:**
  - +1 on accept, −1 on `rsp_valid`, unchanged when both or neither occur.
  - Maximum value LAT+1. It never wraps.
- **`en` deassertion:** `req_ready` goes low in the same cycle and in-flight operations still complete. `en` does not affect the tracker.
- **Requester protocol:** a requester must hold `req_valid`/operands stable until accepted. A requester may drop `req_valid` before being granted; nothing is issued for it.
- **Operand format:** opaque to this block (sign[26], exp[25:18], mant[17:0]); no arithmetic is performed here.

## Timing
- Reset (`rst` low, asynchronous) sets:
  - `ptr` = 0 and all tracker entries to {0, 0}.
  - `add_a` = `add_b` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0.
  - `inflight` = 0, `idle` = 1.
- `req_ready` is 0 while in reset.
- Reset mid-operation discards all in-flight operations: no `rsp_valid` for them after release.
- Latency: accept at edge E0 gives `rsp_valid` high for exactly the one cycle following edge E0+LAT+1.
- Throughput: one accept per cycle. With all requesters continuously valid, grants rotate 0,1,…,NREQ−1,0 with no idle cycles.
- Accept and return in the same cycle: `inflight` is unchanged and `idle` stays low.

## Structure
- Package `fp_add_arb_pkg` contains:
  - `FP_W` = 27, `FP_EXP_W` = 8, `FP_MANT_W` = 18.
  - `FP_ADD_LAT` = 3.
  - Typedef `fp_t` (W bits) and a requester-ID width function.
- Sub-module `rr_arbiter` (`NREQ`):
  - Inputs: `req`, `en`.
  - Outputs: one-hot `grant` and `grant_id`.
  - It contains the `ptr` register and its update on `grant`.
- The top level holds the operand registers, tracker, response registers and counter.

## Test plan
- **Single op:** after reset, requester 2 presents A=0x1FC0000 (1.0) and B=0x2000000 (2.0) with `FpAdd` connected → `req_ready[2]` in the same cycle; `rsp_valid` one cycle after E0+4; `rsp_id`=2; `rsp_sum`=0x2020000 (3.0); `inflight` returns to 0 and `idle`=1.
- **Full contention:** all 4 requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 consecutive `rsp_valid` cycles with IDs in the same order; `inflight` peaks at 4.
- **Round-robin skip:** `ptr`=1 with only requesters 0 and 3 valid → grants 3, then 0, then 3.
- **Enable gating:** drop `en` with 3 ops in flight → `req_ready`=0 immediately; exactly 3 `rsp_valid` pulses follow; `idle` rises after the last one; raising `en` resumes from the held `ptr`.
- **Reset mid-flight:** assert `rst` low with 2 ops in flight → all outputs at reset values; no `rsp_valid` for 10 cycles after release with no requests.
- **Withdrawn request:** requester 1 drops `req_valid` while requester 0 is granted → no issue for 1; `inflight` counts only requester 0's op.
